// File: rtl/ysyx_23060201_pkg.sv
// rtl/ysyx_23060201_pkg.sv - shared opcodes, ALU/immediate enums and decode payload for the IDU
package ysyx_23060201_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [6:0]  F7_BASE     = 7'b0000000;
   localparam logic [6:0]  F7_ALT      = 7'b0100000;
   localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_COPY_B
   } alu_op_e;

   typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

   typedef struct packed {
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      alu_op_e     alu_op;
      logic        src2_imm;
      logic        src1_pc;
      logic        wen;
      logic        mem_ren;
      logic        mem_wen;
      logic [2:0]  mem_funct3;
      logic        branch;
      logic        jal;
      logic        jalr;
      logic        ecall;
      logic        ebreak;
      logic        illegal;
   } decode_t;

endpackage

// File: rtl/ysyx_23060201_idu_if.sv
// rtl/ysyx_23060201_idu_if.sv - fetch-side and execute-side handshake bundle of the decode stage
interface ysyx_23060201_idu_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   import ysyx_23060201_pkg::*;

   logic                  in_valid;
   logic                  in_ready;
   logic [ADDR_WIDTH-1:0] in_pc;
   logic [DATA_WIDTH-1:0] in_inst;
   logic                  out_valid;
   logic                  out_ready;
   logic [ADDR_WIDTH-1:0] out_pc;
   logic [4:0]            out_rs1;
   logic [4:0]            out_rs2;
   logic [4:0]            out_rd;
   logic [31:0]           out_imm;
   alu_op_e               out_alu_op;
   logic                  out_src2_imm;
   logic                  out_src1_pc;
   logic                  out_wen;
   logic                  out_mem_ren;
   logic                  out_mem_wen;
   logic [2:0]            out_mem_funct3;
   logic                  out_branch;
   logic                  out_jal;
   logic                  out_jalr;
   logic                  out_ecall;
   logic                  out_ebreak;
   logic                  out_illegal;

   modport master (
      output in_valid, in_pc, in_inst, out_ready,
      input  in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op,
             out_src2_imm, out_src1_pc, out_wen, out_mem_ren, out_mem_wen, out_mem_funct3,
             out_branch, out_jal, out_jalr, out_ecall, out_ebreak, out_illegal
   );

   modport slave (
      input  in_valid, in_pc, in_inst, out_ready,
      output in_ready, out_valid, out_pc, out_rs1, out_rs2, out_rd, out_imm, out_alu_op,
             out_src2_imm, out_src1_pc, out_wen, out_mem_ren, out_mem_wen, out_mem_funct3,
             out_branch, out_jal, out_jalr, out_ecall, out_ebreak, out_illegal
   );

endinterface

// File: rtl/ysyx_23060201_imm_gen.sv
// rtl/ysyx_23060201_imm_gen.sv - sign-extended RV32I immediate for a given format
module ysyx_23060201_imm_gen
   import ysyx_23060201_pkg::*;
(
   input  logic [31:7] inst,
   input  imm_type_e   imm_type,
   output logic [31:0] imm
);

   always_comb begin
      imm = '0;
      case (imm_type)
         IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
         IMM_U:   imm = {inst[31:12], 12'b0};
         IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/ysyx_23060201_idu.sv
// rtl/ysyx_23060201_idu.sv - RV32I decode stage with a single-entry valid/ready output register
module ysyx_23060201_idu
   import ysyx_23060201_pkg::*;
#(
   parameter int                    ADDR_WIDTH = 32,
   parameter int                    DATA_WIDTH = 32,
   parameter logic [ADDR_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
   input logic                 clk,
   input logic                 rst,
   input logic                 flush,
   ysyx_23060201_idu_if.slave  bus
);

   logic [DATA_WIDTH-1:0] inst;
   logic [6:0]            opcode;
   logic [2:0]            funct3;
   logic [6:0]            funct7;
   imm_type_e             imm_type;
   logic [31:0]           imm_raw;
   logic                  illegal;
   logic                  fire;
   decode_t               dec;
   decode_t               payload_d, payload_q;
   logic [ADDR_WIDTH-1:0] pc_d, pc_q;
   logic                  valid_d, valid_q;

   assign inst   = bus.in_inst;
   assign opcode = inst[6:0];
   assign funct3 = inst[14:12];
   assign funct7 = inst[31:25];

   always_comb begin
      imm_type = IMM_I;
      case (opcode)
         OPC_LUI, OPC_AUIPC: imm_type = IMM_U;
         OPC_JAL:            imm_type = IMM_J;
         OPC_BRANCH:         imm_type = IMM_B;
         OPC_STORE:          imm_type = IMM_S;
         default:            imm_type = IMM_I;
      endcase
   end

   ysyx_23060201_imm_gen u_imm_gen (
      .inst     (inst[31:7]),
      .imm_type (imm_type),
      .imm      (imm_raw)
   );

   always_comb begin
      dec            = '0;
      dec.rs1        = inst[19:15];
      dec.rs2        = inst[24:20];
      dec.rd         = inst[11:7];
      dec.mem_funct3 = funct3;
      dec.alu_op     = ALU_ADD;
      illegal        = 1'b0;
      case (opcode)
         OPC_LUI:    begin dec.imm = imm_raw; dec.alu_op = ALU_COPY_B; dec.src2_imm = 1'b1; dec.wen = 1'b1; end
         OPC_AUIPC:  begin dec.imm = imm_raw; dec.src1_pc = 1'b1; dec.src2_imm = 1'b1; dec.wen = 1'b1; end
         OPC_JAL:    begin dec.imm = imm_raw; dec.src1_pc = 1'b1; dec.jal = 1'b1; dec.wen = 1'b1; end
         OPC_JALR:   begin dec.imm = imm_raw; dec.src1_pc = 1'b1; dec.jalr = 1'b1; dec.wen = 1'b1; end
         OPC_BRANCH: begin dec.imm = imm_raw; dec.branch = 1'b1; end
         OPC_LOAD:   begin dec.imm = imm_raw; dec.src2_imm = 1'b1; dec.mem_ren = 1'b1; dec.wen = 1'b1; end
         OPC_STORE:  begin dec.imm = imm_raw; dec.src2_imm = 1'b1; dec.mem_wen = 1'b1; end
         OPC_OP_IMM: begin
            dec.imm      = imm_raw;
            dec.src2_imm = 1'b1;
            dec.wen      = 1'b1;
            case (funct3)
               3'b000: dec.alu_op = ALU_ADD;
               3'b010: dec.alu_op = ALU_SLT;
               3'b011: dec.alu_op = ALU_SLTU;
               3'b100: dec.alu_op = ALU_XOR;
               3'b110: dec.alu_op = ALU_OR;
               3'b111: dec.alu_op = ALU_AND;
               3'b001: begin
                  dec.imm    = {27'd0, inst[24:20]};
                  dec.alu_op = ALU_SLL;
                  illegal    = (funct7 != F7_BASE);
               end
               default: begin
                  // funct3 101: bit 30 separates SRAI from SRLI, shamt only in the immediate
                  dec.imm    = {27'd0, inst[24:20]};
                  dec.alu_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
                  illegal    = (funct7 != F7_BASE) && (funct7 != F7_ALT);
               end
            endcase
         end
         OPC_OP: begin
            dec.wen = 1'b1;
            case ({funct7, funct3})
               {F7_BASE, 3'b000}: dec.alu_op = ALU_ADD;
               {F7_ALT,  3'b000}: dec.alu_op = ALU_SUB;
               {F7_BASE, 3'b001}: dec.alu_op = ALU_SLL;
               {F7_BASE, 3'b010}: dec.alu_op = ALU_SLT;
               {F7_BASE, 3'b011}: dec.alu_op = ALU_SLTU;
               {F7_BASE, 3'b100}: dec.alu_op = ALU_XOR;
               {F7_BASE, 3'b101}: dec.alu_op = ALU_SRL;
               {F7_ALT,  3'b101}: dec.alu_op = ALU_SRA;
               {F7_BASE, 3'b110}: dec.alu_op = ALU_OR;
               {F7_BASE, 3'b111}: dec.alu_op = ALU_AND;
               default:           illegal    = 1'b1;
            endcase
         end
         OPC_SYSTEM: begin
            if (inst[31:0] == INST_ECALL)       dec.ecall  = 1'b1;
            else if (inst[31:0] == INST_EBREAK) dec.ebreak = 1'b1;
            else                                illegal    = 1'b1;
         end
         default: illegal = 1'b1;
      endcase
      // An illegal entry carries only its raw register fields so the trap sees no side effects
      if (illegal) begin
         dec.imm     = '0;  dec.alu_op  = ALU_ADD; dec.src2_imm = 1'b0; dec.src1_pc = 1'b0;
         dec.wen     = 1'b0; dec.mem_ren = 1'b0;   dec.mem_wen  = 1'b0; dec.branch  = 1'b0;
         dec.jal     = 1'b0; dec.jalr    = 1'b0;   dec.ecall    = 1'b0; dec.ebreak  = 1'b0;
         dec.illegal = 1'b1;
      end
      if (dec.rd == 5'd0) dec.wen = 1'b0;
   end

   assign bus.in_ready = !flush && (!valid_q || bus.out_ready);
   assign fire         = bus.in_valid && bus.in_ready;

   always_comb begin
      valid_d   = valid_q;
      payload_d = payload_q;
      pc_d      = pc_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (fire) begin
         valid_d   = 1'b1;
         payload_d = dec;
         pc_d      = bus.in_pc;
      end else if (bus.out_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q   <= 1'b0;
         payload_q <= '0;
         pc_q      <= RESET_PC;
      end else begin
         valid_q   <= valid_d;
         payload_q <= payload_d;
         pc_q      <= pc_d;
      end
   end

   assign bus.out_valid      = valid_q;
   assign bus.out_pc         = pc_q;
   assign bus.out_rs1        = payload_q.rs1;
   assign bus.out_rs2        = payload_q.rs2;
   assign bus.out_rd         = payload_q.rd;
   assign bus.out_imm        = payload_q.imm;
   assign bus.out_alu_op     = payload_q.alu_op;
   assign bus.out_src2_imm   = payload_q.src2_imm;
   assign bus.out_src1_pc    = payload_q.src1_pc;
   assign bus.out_wen        = payload_q.wen;
   assign bus.out_mem_ren    = payload_q.mem_ren;
   assign bus.out_mem_wen    = payload_q.mem_wen;
   assign bus.out_mem_funct3 = payload_q.mem_funct3;
   assign bus.out_branch     = payload_q.branch;
   assign bus.out_jal        = payload_q.jal;
   assign bus.out_jalr       = payload_q.jalr;
   assign bus.out_ecall      = payload_q.ecall;
   assign bus.out_ebreak     = payload_q.ebreak;
   assign bus.out_illegal    = payload_q.illegal;

endmodule

// File: tb/tb_ysyx_23060201_idu.sv
// tb/tb_ysyx_23060201_idu.sv - scoreboard bench for the RV32I decode stage
module tb_ysyx_23060201_idu;
   import ysyx_23060201_pkg::*;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] imm;
      logic [3:0]  alu;
      logic        src2_imm;
      logic        src1_pc;
      logic        wen;
      logic        mem_ren;
      logic        mem_wen;
      logic [2:0]  f3;
      logic        branch;
      logic        jal;
      logic        jalr;
      logic        ecall;
      logic        ebreak;
      logic        illegal;
   } exp_t;

   localparam logic [31:0] RST_PC = 32'h8000_0000;

   logic clk = 1'b0;
   logic rst;
   logic flush;
   int   tests = 0;
   int   fails = 0;
   exp_t sb[$];
   exp_t mon_e;
   exp_t e;

   always #5 clk = ~clk;

   ysyx_23060201_idu_if bus ();

   ysyx_23060201_idu dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus)
   );

   function automatic exp_t fields(input logic [31:0] pc, input logic [31:0] inst);
      exp_t f;
      f     = '0;
      f.pc  = pc;
      f.rs1 = inst[19:15];
      f.rs2 = inst[24:20];
      f.rd  = inst[11:7];
      f.f3  = inst[14:12];
      f.alu = ALU_ADD;
      return f;
   endfunction

   function automatic exp_t observe();
      exp_t o;
      o = {bus.out_pc, bus.out_rs1, bus.out_rs2, bus.out_rd, bus.out_imm, bus.out_alu_op,
           bus.out_src2_imm, bus.out_src1_pc, bus.out_wen, bus.out_mem_ren, bus.out_mem_wen,
           bus.out_mem_funct3, bus.out_branch, bus.out_jal, bus.out_jalr, bus.out_ecall,
           bus.out_ebreak, bus.out_illegal};
      return o;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_entry(input string tag, input exp_t obs, input exp_t exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_accept(input exp_t x);
      bit done;
      done = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            sb.push_back(x);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      bus.in_valid = 1'b0;
      tests++;
      assert (done) else begin
         fails++;
         $error("FAIL accept_timeout: observed not accepted expected accepted pc %h", x.pc);
      end
   endtask

   task automatic send(input logic [31:0] pc, input logic [31:0] inst, input exp_t x);
      bus.in_valid = 1'b1;
      bus.in_pc    = pc;
      bus.in_inst  = inst;
      wait_accept(x);
   endtask

   // Every downstream handshake must retire exactly the oldest expected entry
   always @(negedge clk) begin
      if (!rst && bus.out_valid && bus.out_ready) begin
         tests++;
         assert (sb.size() != 0) else begin
            fails++;
            $error("FAIL unexpected_out: observed pc %h expected no entry", bus.out_pc);
         end
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            assert (observe() === mon_e) else begin
               fails++;
               $error("FAIL decode_pc_%h: observed %h expected %h", mon_e.pc, observe(), mon_e);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed simulation still running expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; flush = 1'b0;
      bus.in_valid = 1'b0; bus.in_pc = '0; bus.in_inst = '0; bus.out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      e = '0; e.pc = RST_PC;
      chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
      chk_entry("reset_payload", observe(), e);
      rst = 1'b0;
      @(posedge clk); #1;
      chk("idle_in_ready", {31'd0, bus.in_ready}, 32'd1);

      bus.out_ready = 1'b1;
      e = fields(32'h8000_0000, 32'h0050_0093); e.imm = 32'd5; e.src2_imm = 1; e.wen = 1;
      send(32'h8000_0000, 32'h0050_0093, e);
      e = fields(32'h8000_0004, 32'hFE00_0EE3); e.imm = 32'hFFFF_FFFC; e.branch = 1;
      send(32'h8000_0004, 32'hFE00_0EE3, e);
      e = fields(32'h8000_0008, 32'h1234_5137); e.imm = 32'h1234_5000; e.alu = ALU_COPY_B;
      e.src2_imm = 1; e.wen = 1;
      send(32'h8000_0008, 32'h1234_5137, e);
      e = fields(32'h8000_000C, 32'h4030_D193); e.imm = 32'd3; e.alu = ALU_SRA;
      e.src2_imm = 1; e.wen = 1;
      send(32'h8000_000C, 32'h4030_D193, e);
      e = fields(32'h8000_0010, 32'h4073_02B3); e.alu = ALU_SUB; e.wen = 1;
      send(32'h8000_0010, 32'h4073_02B3, e);
      e = fields(32'h8000_0014, 32'hFFC1_2403); e.imm = 32'hFFFF_FFFC; e.src2_imm = 1;
      e.mem_ren = 1; e.wen = 1;
      send(32'h8000_0014, 32'hFFC1_2403, e);
      e = fields(32'h8000_0018, 32'h0081_2423); e.imm = 32'd8; e.src2_imm = 1; e.mem_wen = 1;
      send(32'h8000_0018, 32'h0081_2423, e);
      e = fields(32'h8000_001C, 32'h0100_00EF); e.imm = 32'd16; e.src1_pc = 1; e.jal = 1; e.wen = 1;
      send(32'h8000_001C, 32'h0100_00EF, e);
      e = fields(32'h8000_0020, 32'h0010_0013); e.imm = 32'd1; e.src2_imm = 1;
      send(32'h8000_0020, 32'h0010_0013, e);
      e = fields(32'h8000_0024, 32'h0210_1093); e.illegal = 1;
      send(32'h8000_0024, 32'h0210_1093, e);
      e = fields(32'h8000_0028, 32'h0010_0073); e.ebreak = 1;
      send(32'h8000_0028, 32'h0010_0073, e);
      e = fields(32'h8000_002C, 32'h0000_0073); e.ecall = 1;
      send(32'h8000_002C, 32'h0000_0073, e);
      e = fields(32'h8000_0030, 32'hFFFF_FFFF); e.illegal = 1;
      send(32'h8000_0030, 32'hFFFF_FFFF, e);
      repeat (2) @(posedge clk);
      #1;
      chk("drained_all", sb.size(), 32'd0);

      bus.out_ready = 1'b0;
      e = fields(32'h8000_0100, 32'h0070_0113); e.imm = 32'd7; e.src2_imm = 1; e.wen = 1;
      send(32'h8000_0100, 32'h0070_0113, e);
      bus.in_valid = 1'b1; bus.in_pc = 32'h8000_0104; bus.in_inst = 32'h0080_0193;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("hold_in_ready", {31'd0, bus.in_ready}, 32'd0);
         chk("hold_out_pc", bus.out_pc, 32'h8000_0100);
         chk("hold_out_imm", bus.out_imm, 32'd7);
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      e = fields(32'h8000_0104, 32'h0080_0193); e.imm = 32'd8; e.src2_imm = 1; e.wen = 1;
      wait_accept(e);
      repeat (3) @(posedge clk);
      #1;
      chk("hold_release_drained", sb.size(), 32'd0);

      bus.out_ready = 1'b0;
      e = fields(32'h8000_0200, 32'h0090_0213); e.imm = 32'd9; e.src2_imm = 1; e.wen = 1;
      send(32'h8000_0200, 32'h0090_0213, e);
      bus.in_valid = 1'b1; bus.in_pc = 32'h8000_0204; bus.in_inst = 32'h00A0_0293; flush = 1'b1;
      @(negedge clk);
      chk("flush_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("flush_held_valid", {31'd0, bus.out_valid}, 32'd1);
      @(posedge clk); #1;
      flush = 1'b0; bus.in_valid = 1'b0;
      chk("flush_out_valid", {31'd0, bus.out_valid}, 32'd0);
      if (sb.size() != 0) sb.delete(sb.size() - 1);
      bus.out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("flush_no_emit", {31'd0, bus.out_valid}, 32'd0);

      bus.out_ready = 1'b0;
      e = fields(32'h8000_0300, 32'h00B0_0313); e.imm = 32'd11; e.src2_imm = 1; e.wen = 1;
      send(32'h8000_0300, 32'h00B0_0313, e);
      chk("pre_reset_valid", {31'd0, bus.out_valid}, 32'd1);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("async_rst_pc", bus.out_pc, RST_PC);
      chk("async_rst_imm", bus.out_imm, 32'd0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      chk("post_reset_valid", {31'd0, bus.out_valid}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
